// File: rtl/uart_bus_loader.sv
// Byte-command bus initiator: turns 'W'/'R' frames from the UART RX stage into
// native memory-bus transactions and streams the response bytes back to TX.
module uart_bus_loader #(
  parameter int BYTE_TIMEOUT = 1_000_000,
  parameter int BUS_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int BYTE_TW = $clog2(BYTE_TIMEOUT + 1);
  localparam int BUS_TW  = $clog2(BUS_TIMEOUT + 1);

  localparam logic [BYTE_TW-1:0] BYTE_LAST = BYTE_TW'(BYTE_TIMEOUT - 1);
  localparam logic [BYTE_TW-1:0] BYTE_MAX  = BYTE_TW'(BYTE_TIMEOUT);
  localparam logic [BUS_TW-1:0]  BUS_LAST  = BUS_TW'(BUS_TIMEOUT - 1);
  localparam logic [BUS_TW-1:0]  BUS_MAX   = BUS_TW'(BUS_TIMEOUT);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] RSP_BAD   = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         byte_cnt;
  logic [31:0]        addr_reg;
  logic [31:0]        data_reg;
  logic               is_write;
  logic [31:0]        resp_buf;
  logic [1:0]         resp_left;
  logic [BYTE_TW-1:0] byte_timer;
  logic [BUS_TW-1:0]  bus_timer;

  logic known_cmd;
  logic byte_expired;
  logic bus_expired;

  // A byte arriving on the expiry cycle wins, so expiry is gated by !rx_valid.
  assign known_cmd    = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
  assign byte_expired = !rx_valid && (byte_timer == BYTE_LAST);
  assign bus_expired  = !mem_ready && (bus_timer == BUS_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rx_valid) state_next = known_cmd ? ADDR : RESP;
      end
      ADDR: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) state_next = is_write ? DATA : BUS;
        end else if (byte_expired) begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) state_next = BUS;
        end else if (byte_expired) begin
          state_next = IDLE;
        end
      end
      BUS: begin
        if (mem_ready || bus_expired) state_next = RESP;
      end
      RESP: begin
        if (tx_ready && (resp_left == 2'd0)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Field capture, timers and the response shift register; resp_left holds
  // the number of bytes still to send after the one currently on tx_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      is_write   <= 1'b0;
      resp_buf   <= '0;
      resp_left  <= '0;
      byte_timer <= '0;
      bus_timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          byte_cnt   <= '0;
          byte_timer <= '0;
          bus_timer  <= '0;
          if (rx_valid) begin
            is_write <= (rx_data == CMD_WRITE);
            if (!known_cmd) begin
              resp_buf  <= {24'h0, RSP_BAD};
              resp_left <= 2'd0;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            addr_reg[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt   <= byte_cnt + 2'd1;
            byte_timer <= '0;
          end else if (byte_timer != BYTE_MAX) begin
            byte_timer <= byte_timer + 1'b1;
          end
        end
        DATA: begin
          if (rx_valid) begin
            data_reg[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt   <= byte_cnt + 2'd1;
            byte_timer <= '0;
          end else if (byte_timer != BYTE_MAX) begin
            byte_timer <= byte_timer + 1'b1;
          end
        end
        BUS: begin
          if (mem_ready) begin
            resp_buf  <= is_write ? {24'h0, RSP_OK} : mem_rdata;
            resp_left <= is_write ? 2'd0 : 2'd3;
          end else if (bus_expired) begin
            resp_buf  <= {24'h0, RSP_ERR};
            resp_left <= 2'd0;
          end else if (bus_timer != BUS_MAX) begin
            bus_timer <= bus_timer + 1'b1;
          end
        end
        RESP: begin
          if (tx_ready) begin
            resp_buf  <= {8'h00, resp_buf[31:8]};
            resp_left <= resp_left - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_valid  = (state == RESP);
    tx_data   = tx_valid ? resp_buf[7:0] : 8'h00;
    mem_valid = (state == BUS);
    mem_addr  = mem_valid ? (addr_reg & 32'hFFFF_FFFC) : 32'h0;
    mem_wdata = mem_valid ? data_reg : 32'h0;
    mem_wstrb = (mem_valid && is_write) ? 4'hF : 4'h0;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_bus_loader.sv
// Directed bench for uart_bus_loader: a table of frames plus hand-written
// sequences for back-pressure, bus/byte timeouts and reset during a bus access.
module tb_uart_bus_loader;

  localparam int BYTE_TO = 20;
  localparam int BUS_TO  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_bus_loader #(.BYTE_TIMEOUT(BYTE_TO), .BUS_TIMEOUT(BUS_TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  logic        resp_en   = 1'b1;
  int          resp_lat  = 1;
  logic [31:0] resp_data = 32'h0;
  logic        bp_mode   = 1'b0;

  int          bus_wait = 0;
  int          bus_count = 0;
  int          valid_cycles = 0;
  int          bus_unstable = 0;
  int          tx_unstable = 0;
  int          tx_cycles = 0;
  int          cyc = 0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic [3:0]  cap_wstrb = 4'h0;
  logic        prev_mem_valid = 1'b0;
  logic        prev_tx_valid = 1'b0;
  logic        prev_tx_acc = 1'b0;
  logic [7:0]  prev_tx_data = 8'h00;
  logic [7:0]  tx_q[$];

  // Bus responder and TX monitor, both sampling mid-cycle.
  always @(negedge clk) begin
    if (mem_valid) begin
      valid_cycles++;
      if (!prev_mem_valid) begin
        bus_count++;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_wstrb = mem_wstrb;
      end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_wstrb !== cap_wstrb) begin
        bus_unstable++;
      end
    end
    if (mem_valid && resp_en) begin
      bus_wait++;
      mem_ready = (bus_wait >= resp_lat);
      mem_rdata = mem_ready ? resp_data : 32'h0;
    end else begin
      bus_wait  = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end
    prev_mem_valid = mem_valid;
    if (tx_valid) tx_cycles++;
    if (tx_valid && prev_tx_valid && !prev_tx_acc && tx_data !== prev_tx_data) tx_unstable++;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    prev_tx_valid = tx_valid;
    prev_tx_data  = tx_data;
    prev_tx_acc   = tx_valid && tx_ready;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    tx_ready = bp_mode ? ((cyc % 11) == 10) : 1'b1;
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [71:0] bytes;
    int          nbytes;
    int          lat;
    logic [31:0] rdata;
    int          exp_bus;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        chk_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_resp;
    int          exp_n;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic sendFrame(input logic [71:0] bytes, input int n);
    for (int i = 0; i < n; i++) applyStimulus(bytes[8*i +: 8]);
  endtask

  task automatic waitResp(input string name, input int base, input int n);
    int c;
    c = 0;
    while ((tx_q.size() - base) < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    c = 0;
    while (busy && c < 50) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    checkOutput({name, "_tx_count"}, tx_q.size() - base, n);
    checkOutput({name, "_idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic checkBytes(input string name, input int base, input logic [31:0] exp, input int n);
    for (int j = 0; j < n; j++) begin
      if (base + j < tx_q.size())
        checkOutput($sformatf("%s_byte%0d", name, j), {24'h0, tx_q[base + j]}, {24'h0, exp[8*j +: 8]});
    end
  endtask

  task automatic runTimeout(input string name, input logic [71:0] bytes, input int n);
    int base_tx, base_bus, base_valid;
    base_tx = tx_q.size(); base_bus = bus_count; base_valid = valid_cycles;
    resp_en = 1'b0;
    sendFrame(bytes, n);
    applyStimulus(8'h41);
    waitResp(name, base_tx, 1);
    checkOutput({name, "_valid_cycles"}, valid_cycles - base_valid, BUS_TO);
    checkOutput({name, "_bus_count"}, bus_count - base_bus, 1);
    checkBytes(name, base_tx, 32'h45, 1);
    resp_en = 1'b1;
  endtask

  initial begin
    int base_tx, base_bus, base_unst, base_cyc, c;

    vecs[0] = '{bytes: 72'hDE_AD_BE_EF_00_00_10_00_57, nbytes: 9, lat: 1, rdata: 32'h0,
                exp_bus: 1, exp_addr: 32'h0000_1000, exp_wdata: 32'hDEAD_BEEF, chk_wdata: 1'b1,
                exp_wstrb: 4'hF, exp_resp: 32'h4B, exp_n: 1};
    vecs[1] = '{bytes: 72'h00_00_10_00_52, nbytes: 5, lat: 3, rdata: 32'h1234_5678,
                exp_bus: 1, exp_addr: 32'h0000_1000, exp_wdata: 32'h0, chk_wdata: 1'b0,
                exp_wstrb: 4'h0, exp_resp: 32'h1234_5678, exp_n: 4};
    vecs[2] = '{bytes: 72'h00_00_00_03_52, nbytes: 5, lat: 1, rdata: 32'hA5A5_0F0F,
                exp_bus: 1, exp_addr: 32'h0000_0000, exp_wdata: 32'h0, chk_wdata: 1'b0,
                exp_wstrb: 4'h0, exp_resp: 32'hA5A5_0F0F, exp_n: 4};
    vecs[3] = '{bytes: 72'h41, nbytes: 1, lat: 1, rdata: 32'h0,
                exp_bus: 0, exp_addr: 32'h0, exp_wdata: 32'h0, chk_wdata: 1'b0,
                exp_wstrb: 4'h0, exp_resp: 32'h3F, exp_n: 1};
    vecs[4] = '{bytes: 72'h12_34_56_78_20_00_00_04_57, nbytes: 9, lat: 2, rdata: 32'h0,
                exp_bus: 1, exp_addr: 32'h2000_0004, exp_wdata: 32'h1234_5678, chk_wdata: 1'b1,
                exp_wstrb: 4'hF, exp_resp: 32'h4B, exp_n: 1};
    vecs[5] = '{bytes: 72'h80_00_00_07_52, nbytes: 5, lat: 1, rdata: 32'hCAFE_F00D,
                exp_bus: 1, exp_addr: 32'h8000_0004, exp_wdata: 32'h0, chk_wdata: 1'b0,
                exp_wstrb: 4'h0, exp_resp: 32'hCAFE_F00D, exp_n: 4};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    checkOutput("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    checkOutput("rst_tx_data", {24'h0, tx_data}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    base_unst = bus_unstable;
    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      base_tx = tx_q.size(); base_bus = bus_count;
      resp_lat = vecs[i].lat; resp_data = vecs[i].rdata;
      sendFrame(vecs[i].bytes, vecs[i].nbytes);
      waitResp(nm, base_tx, vecs[i].exp_n);
      checkOutput({nm, "_bus_count"}, bus_count - base_bus, vecs[i].exp_bus);
      if (vecs[i].exp_bus > 0) begin
        checkOutput({nm, "_addr"}, cap_addr, vecs[i].exp_addr);
        checkOutput({nm, "_wstrb"}, {28'h0, cap_wstrb}, {28'h0, vecs[i].exp_wstrb});
        if (vecs[i].chk_wdata) checkOutput({nm, "_wdata"}, cap_wdata, vecs[i].exp_wdata);
      end
      checkBytes(nm, base_tx, vecs[i].exp_resp, vecs[i].exp_n);
    end
    checkOutput("bus_stable", bus_unstable - base_unst, 0);

    // Back-pressure: tx_ready pulses once every 11 cycles.
    base_tx = tx_q.size(); base_unst = tx_unstable; base_cyc = tx_cycles;
    resp_lat = 2; resp_data = 32'h1234_5678;
    bp_mode = 1'b1;
    sendFrame(72'h00_00_10_00_52, 5);
    waitResp("bp", base_tx, 4);
    bp_mode = 1'b0;
    checkBytes("bp", base_tx, 32'h1234_5678, 4);
    checkOutput("bp_tx_stable", tx_unstable - base_unst, 0);
    checkOutput("bp_held", {31'h0, (tx_cycles - base_cyc) >= 34}, 32'h1);

    runTimeout("rd_timeout", 72'h00_00_20_00_52, 5);
    runTimeout("wr_timeout", 72'h44_33_22_11_00_00_00_08_57, 9);

    // Byte timeout: partial frame abandoned, next read works.
    base_tx = tx_q.size(); base_bus = bus_count;
    sendFrame(72'h00_57, 2);
    repeat (10) @(negedge clk);
    checkOutput("bto_still_busy", {31'h0, busy}, 32'h1);
    repeat (20) @(negedge clk);
    checkOutput("bto_idle", {31'h0, busy}, 32'h0);
    checkOutput("bto_no_bus", bus_count - base_bus, 0);
    checkOutput("bto_no_tx", tx_q.size() - base_tx, 0);
    resp_lat = 1; resp_data = 32'h1122_3344;
    sendFrame(72'h00_00_00_00_52, 5);
    waitResp("bto_read", base_tx, 4);
    checkOutput("bto_read_addr", cap_addr, 32'h0);
    checkBytes("bto_read", base_tx, 32'h1122_3344, 4);

    // Reset while the bus request is outstanding.
    base_tx = tx_q.size();
    resp_en = 1'b0;
    sendFrame(72'hDE_AD_BE_EF_00_00_10_00_57, 9);
    c = 0;
    while (!mem_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    checkOutput("mid_bus_valid", {31'h0, mem_valid}, 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    checkOutput("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    resp_en = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("mid_rst_no_tx", tx_q.size() - base_tx, 0);
    checkOutput("mid_rst_idle", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
